// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: RAW/WAW stall detection with fixed and variable latency tracking; stalls are combinational, state updates next edge.
// Optional perf counters under HAZARD_SCOREBOARD_PERF_EN; issue_ready drops on any stall, flush or clear_all.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 3,
  parameter int NUM_DST    = 2,
  parameter int LAT_W      = 3,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] issue_src,
  input  logic [NUM_SRC-1:0]            issue_src_en,
  input  logic [NUM_DST*REG_ADDR_W-1:0] issue_dst,
  input  logic [NUM_DST-1:0]            issue_dst_en,
  input  logic [NUM_DST*LAT_W-1:0]      issue_lat,
  input  logic                          cpl_valid,
  input  logic [REG_ADDR_W-1:0]         cpl_rd,
  input  logic                          flush,
  input  logic                          clear_all,
  output logic                          stall_raw,
  output logic                          stall_waw,
  output logic [$clog2(NUM_SRC):0]      stall_src,
  output logic [NUM_REGS-1:0]           busy_vec,
`ifdef HAZARD_SCOREBOARD_PERF_EN
  output logic [31:0]                   raw_stall_cnt,
  output logic [31:0]                   waw_stall_cnt,
  output logic [31:0]                   issued_cnt,
`endif
  output logic                          cpl_err
);

  localparam int SRC_W      = $clog2(NUM_SRC) + 1;
  localparam int ADDR_SPACE = 1 << REG_ADDR_W;

  logic [LAT_W-1:0]      cnt_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q;
  logic [ADDR_SPACE-1:0] busy_x, pend_x, one_x;
  logic                  dup_waw;
  logic                  accept;

  function automatic logic in_range(input logic [REG_ADDR_W-1:0] a);
    return {1'b0, a} < (REG_ADDR_W+1)'(NUM_REGS);
  endfunction

  // Views padded to the full address space so any address indexes safely; r0 stays idle.
  always_comb begin
    busy_x = '0;
    pend_x = '0;
    one_x  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_x[r] = (cnt_q[r] != '0) | pend_q[r];
      pend_x[r] = pend_q[r];
      one_x[r]  = (cnt_q[r] == LAT_W'(1));
    end
  end

  assign busy_vec = busy_x[NUM_REGS-1:0];

  always_comb begin
    stall_raw = 1'b0;
    stall_src = '0;
    dup_waw   = 1'b0;
    stall_waw = 1'b0;
    // Descending scan so the lowest conflicting slot is reported.
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (issue_src_en[s] && issue_src[s*REG_ADDR_W +: REG_ADDR_W] != '0 &&
          busy_x[issue_src[s*REG_ADDR_W +: REG_ADDR_W]] &&
          !(BYPASS_EN && !pend_x[issue_src[s*REG_ADDR_W +: REG_ADDR_W]] &&
            one_x[issue_src[s*REG_ADDR_W +: REG_ADDR_W]])) begin
        stall_raw = 1'b1;
        stall_src = SRC_W'(s + 1);
      end
    end
    for (int i = 0; i < NUM_DST; i++) begin
      if (issue_dst_en[i] && busy_x[issue_dst[i*REG_ADDR_W +: REG_ADDR_W]])
        stall_waw = 1'b1;
      for (int j = i + 1; j < NUM_DST; j++) begin
        if (issue_dst_en[i] && issue_dst_en[j] &&
            issue_dst[i*REG_ADDR_W +: REG_ADDR_W] != '0 &&
            issue_dst[i*REG_ADDR_W +: REG_ADDR_W] == issue_dst[j*REG_ADDR_W +: REG_ADDR_W])
          dup_waw = 1'b1;
      end
    end
    stall_waw = stall_waw | dup_waw;
  end

  assign issue_ready = !stall_raw && !stall_waw && !flush && !clear_all;
  assign accept      = issue_valid && issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      pend_q  <= '0;
      cpl_err <= 1'b0;
    end else begin
      cpl_err <= cpl_valid && !clear_all && !pend_x[cpl_rd];
      if (clear_all) begin
        for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        pend_q <= '0;
      end else begin
        for (int r = 0; r < NUM_REGS; r++)
          if (cnt_q[r] != '0) cnt_q[r] <= cnt_q[r] - 1'b1;
        if (cpl_valid && pend_x[cpl_rd]) pend_q[cpl_rd] <= 1'b0;
        // Issue is applied last so it overrides a same-register completion.
        if (accept) begin
          for (int d = 0; d < NUM_DST; d++) begin
            if (issue_dst_en[d] && issue_dst[d*REG_ADDR_W +: REG_ADDR_W] != '0 &&
                in_range(issue_dst[d*REG_ADDR_W +: REG_ADDR_W])) begin
              if (issue_lat[d*LAT_W +: LAT_W] != '0) begin
                cnt_q[issue_dst[d*REG_ADDR_W +: REG_ADDR_W]]  <= issue_lat[d*LAT_W +: LAT_W];
                pend_q[issue_dst[d*REG_ADDR_W +: REG_ADDR_W]] <= 1'b0;
              end else begin
                cnt_q[issue_dst[d*REG_ADDR_W +: REG_ADDR_W]]  <= '0;
                pend_q[issue_dst[d*REG_ADDR_W +: REG_ADDR_W]] <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  // Saturating counters; deliberately untouched by clear_all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_stall_cnt <= '0;
      waw_stall_cnt <= '0;
      issued_cnt    <= '0;
    end else begin
      if (issue_valid && stall_raw && raw_stall_cnt != '1) raw_stall_cnt <= raw_stall_cnt + 1'b1;
      if (issue_valid && stall_waw && waw_stall_cnt != '1) waw_stall_cnt <= waw_stall_cnt + 1'b1;
      if (accept && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (bypass enabled).
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [14:0] issue_src;
  logic [2:0]  issue_src_en;
  logic [9:0]  issue_dst;
  logic [1:0]  issue_dst_en;
  logic [5:0]  issue_lat;
  logic        cpl_valid;
  logic [4:0]  cpl_rd;
  logic        flush;
  logic        clear_all;
  logic        stall_raw;
  logic        stall_waw;
  logic [2:0]  stall_src;
  logic [31:0] busy_vec;
  logic        cpl_err;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src(issue_src), .issue_src_en(issue_src_en),
    .issue_dst(issue_dst), .issue_dst_en(issue_dst_en), .issue_lat(issue_lat),
    .cpl_valid(cpl_valid), .cpl_rd(cpl_rd),
    .flush(flush), .clear_all(clear_all),
    .stall_raw(stall_raw), .stall_waw(stall_waw), .stall_src(stall_src),
    .busy_vec(busy_vec), .cpl_err(cpl_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] sen,
                        input logic [4:0] d0, input logic [4:0] d1, input logic [1:0] den,
                        input logic [2:0] l0, input logic [2:0] l1);
    issue_valid  = v;
    issue_src    = {s2, s1, s0};
    issue_src_en = sen;
    issue_dst    = {d1, d0};
    issue_dst_en = den;
    issue_lat    = {l1, l0};
    #1;
  endtask

  task automatic idle();
    bundle(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 2'b00, 3'd0, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0; cpl_valid = 1'b0; cpl_rd = '0; flush = 1'b0; clear_all = 1'b0;
    idle();
    #2;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_ready", {31'b0, issue_ready}, 32'h1);
    chk("rst_stall", {29'b0, stall_raw, stall_waw, 1'b0}, 32'h0);
    chk("rst_src", {29'b0, stall_src}, 32'h0);
    chk("rst_cpl_err", {31'b0, cpl_err}, 32'h0);
    #5 rst_n = 1'b1;
    tick();

    // Fixed latency 3 on r5 with bypass at count==1
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 5'd0, 2'b01, 3'd3, 3'd0);
    chk("lat3_ready", {31'b0, issue_ready}, 32'h1);
    tick();
    bundle(1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 5'd0, 5'd0, 2'b00, 3'd0, 3'd0);
    chk("lat3_busy", busy_vec, 32'h20);
    chk("raw_c3", {31'b0, stall_raw}, 32'h1);
    chk("raw_src_slot0", {29'b0, stall_src}, 32'h1);
    chk("raw_ready", {31'b0, issue_ready}, 32'h0);
    tick();
    bundle(1'b1, 5'd1, 5'd3, 5'd5, 3'b111, 5'd0, 5'd0, 2'b00, 3'd0, 3'd0);
    chk("raw_c2", {31'b0, stall_raw}, 32'h1);
    chk("raw_src_slot2", {29'b0, stall_src}, 32'h3);
    tick();
    chk("bypass_raw", {31'b0, stall_raw}, 32'h0);
    chk("bypass_ready", {31'b0, issue_ready}, 32'h1);
    chk("bypass_busy", busy_vec, 32'h20);
    tick();
    idle();
    chk("lat3_done", busy_vec, 32'h0);

    // Variable latency on r7, resolved by completion
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 5'd0, 2'b01, 3'd0, 3'd0);
    tick();
    bundle(1'b0, 5'd7, 5'd7, 5'd0, 3'b010, 5'd0, 5'd0, 2'b00, 3'd0, 3'd0);
    chk("var_busy", busy_vec, 32'h80);
    chk("var_raw", {31'b0, stall_raw}, 32'h1);
    chk("var_src", {29'b0, stall_src}, 32'h2);
    tick(); tick(); tick();
    chk("var_raw_hold", {31'b0, stall_raw}, 32'h1);
    chk("var_busy_hold", busy_vec, 32'h80);
    cpl_valid = 1'b1; cpl_rd = 5'd7; #1;
    chk("var_raw_cplcyc", {31'b0, stall_raw}, 32'h1);
    tick();
    cpl_valid = 1'b0; #1;
    chk("var_raw_clear", {31'b0, stall_raw}, 32'h0);
    chk("var_ready", {31'b0, issue_ready}, 32'h1);
    chk("var_busy_clear", busy_vec, 32'h0);
    chk("var_no_err", {31'b0, cpl_err}, 32'h0);

    // WAW on r9 lat 2, no bypass for destinations
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 5'd0, 2'b01, 3'd2, 3'd0);
    tick();
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 5'd0, 2'b01, 3'd1, 3'd0);
    chk("waw_c2", {31'b0, stall_waw}, 32'h1);
    chk("waw_noraw", {31'b0, stall_raw}, 32'h0);
    chk("waw_ready", {31'b0, issue_ready}, 32'h0);
    tick();
    chk("waw_c1", {31'b0, stall_waw}, 32'h1);
    tick();
    chk("waw_clear", {31'b0, stall_waw}, 32'h0);
    chk("waw_busy0", busy_vec, 32'h0);
    tick();
    idle();
    chk("waw_reissue", busy_vec, 32'h200);
    tick();
    chk("waw_lat1_done", busy_vec, 32'h0);
    bundle(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd4, 5'd4, 2'b11, 3'd1, 3'd1);
    chk("dup_waw", {31'b0, stall_waw}, 32'h1);
    bundle(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd4, 5'd4, 2'b01, 3'd1, 3'd1);
    chk("dup_disabled", {31'b0, stall_waw}, 32'h0);
    chk("ready_no_valid", {31'b0, issue_ready}, 32'h1);
    idle();

    // Spurious completions
    cpl_valid = 1'b1; cpl_rd = 5'd12; #1;
    chk("err12_pre", {31'b0, cpl_err}, 32'h0);
    tick();
    cpl_valid = 1'b0; #1;
    chk("err12", {31'b0, cpl_err}, 32'h1);
    chk("err12_busy", busy_vec, 32'h0);
    tick();
    chk("err12_pulse", {31'b0, cpl_err}, 32'h0);
    cpl_valid = 1'b1; cpl_rd = 5'd0;
    tick();
    cpl_valid = 1'b0; #1;
    chk("err0", {31'b0, cpl_err}, 32'h1);
    tick();

    // clear_all wipes pending and counting entries
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd3, 5'd6, 2'b11, 3'd0, 3'd4);
    tick();
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd10, 5'd0, 2'b01, 3'd2, 3'd0);
    chk("clr_busy_pre", busy_vec, 32'h48);
    clear_all = 1'b1; cpl_valid = 1'b1; cpl_rd = 5'd3; #1;
    chk("clr_ready", {31'b0, issue_ready}, 32'h0);
    tick();
    clear_all = 1'b0; cpl_valid = 1'b0; idle();
    chk("clr_busy", busy_vec, 32'h0);
    chk("clr_no_err", {31'b0, cpl_err}, 32'h0);
    cpl_valid = 1'b1; cpl_rd = 5'd3;
    tick();
    cpl_valid = 1'b0; #1;
    chk("clr_late_err", {31'b0, cpl_err}, 32'h1);

    // Register 0 never tracked
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b001, 5'd0, 5'd0, 2'b11, 3'd0, 3'd3);
    chk("r0_nostall", {30'b0, stall_raw, stall_waw}, 32'h0);
    chk("r0_ready", {31'b0, issue_ready}, 32'h1);
    tick();
    idle();
    chk("r0_busy", busy_vec, 32'h0);

    // flush blocks acceptance only
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd11, 5'd0, 2'b01, 3'd2, 3'd0);
    flush = 1'b1; #1;
    chk("flush_ready", {31'b0, issue_ready}, 32'h0);
    tick();
    flush = 1'b0; idle();
    chk("flush_busy", busy_vec, 32'h0);

    // Asynchronous reset mid-operation
    bundle(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd8, 5'd0, 2'b01, 3'd0, 3'd0);
    tick();
    idle();
    chk("pre_rst_busy", busy_vec, 32'h100);
    rst_n = 1'b0; #1;
    chk("async_rst_busy", busy_vec, 32'h0);
    rst_n = 1'b1; #1;
    cpl_valid = 1'b1; cpl_rd = 5'd8;
    tick();
    cpl_valid = 1'b0; #1;
    chk("post_rst_err", {31'b0, cpl_err}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
